// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: registers operands and decodes ALUOp/funct into the
// control bits of a ripple ALU built from 1-bit slices (Ainvert, Binvert,
// slice-0 CarryIn, Operation). Single-entry valid/ready buffer with flush.
module id_ex_alu_issue #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_alu_src,
    input  logic [1:0]      in_alu_op,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_reg_write,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic            out_ainvert,
    output logic            out_binvert,
    output logic            out_carry_in,
    output logic [1:0]      out_operation,
    output logic [REGW-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_illegal
);

    // Slice controls, packed as {ainvert, binvert, operation}.
    typedef struct packed {
        logic       ainvert;
        logic       binvert;
        logic [1:0] operation;
    } ctl_t;

    localparam ctl_t CTL_ADD = 4'b0_0_10;
    localparam ctl_t CTL_SUB = 4'b0_1_10;
    localparam ctl_t CTL_AND = 4'b0_0_00;
    localparam ctl_t CTL_OR  = 4'b0_0_01;
    localparam ctl_t CTL_SLT = 4'b0_1_11;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    ctl_t            ctl_dec;
    logic            illegal_dec;
    logic            xfer;
    logic            load;

    logic            valid_d,     valid_q;
    logic [XLEN-1:0] a_d,         a_q;
    logic [XLEN-1:0] b_d,         b_q;
    ctl_t            ctl_d,       ctl_q;
    logic [REGW-1:0] rd_d,        rd_q;
    logic            reg_write_d, reg_write_q;
    logic            illegal_d,   illegal_q;

    // A held beat that is not being consumed blocks the input side.
    assign in_ready = !valid_q || out_ready;
    assign xfer     = in_valid && in_ready;
    // A flush discards the incoming beat as well as the held one.
    assign load     = xfer && !flush;

    // Decode ALUOp/funct3/funct7[5] into slice controls; unsupported encodings fall back to ADD.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        ctl_dec     = CTL_ADD;
        illegal_dec = 1'b0;
        case (in_alu_op)
            ALUOP_MEM:    ctl_dec = CTL_ADD;
            ALUOP_BRANCH: ctl_dec = CTL_SUB;
            ALUOP_RTYPE: begin
                case (in_funct3)
                    F3_ADD:  ctl_dec = in_funct7_5 ? CTL_SUB : CTL_ADD;
                    F3_AND:  ctl_dec = CTL_AND;
                    F3_OR:   ctl_dec = CTL_OR;
                    // SLT has no funct7[5]=1 variant, so that encoding is rejected.
                    F3_SLT: begin
                        if (in_funct7_5) illegal_dec = 1'b1;
                        else             ctl_dec     = CTL_SLT;
                    end
                    default: illegal_dec = 1'b1;
                endcase
            end
            ALUOP_ITYPE: begin
                // funct7[5] is part of the immediate here and plays no role.
                case (in_funct3)
                    F3_ADD:  ctl_dec = CTL_ADD;
                    F3_AND:  ctl_dec = CTL_AND;
                    F3_OR:   ctl_dec = CTL_OR;
                    F3_SLT:  ctl_dec = CTL_SLT;
                    default: illegal_dec = 1'b1;
                endcase
            end
            default: illegal_dec = 1'b1;
        endcase
    end

    // Next-state: flush wins, then a new transfer, then completion drains the stage.
    always_comb begin
        valid_d     = valid_q;
        a_d         = a_q;
        b_d         = b_q;
        ctl_d       = ctl_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            a_d         = in_rs1;
            b_d         = in_alu_src ? in_imm : in_rs2;
            ctl_d       = ctl_dec;
            rd_d        = in_rd;
            reg_write_d = in_reg_write && !illegal_dec;
            illegal_d   = illegal_dec;
        end
    end

    // Stage registers; all outputs read zero while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload registers are reset too, because downstream sees every output as 0 in reset.
            valid_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            ctl_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            valid_q     <= valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctl_q       <= ctl_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_a         = a_q;
    assign out_b         = b_q;
    assign out_ainvert   = ctl_q.ainvert;
    assign out_binvert   = ctl_q.binvert;
    // Binvert plus a carry of 1 into slice 0 forms the two's-complement subtract.
    assign out_carry_in  = ctl_q.binvert;
    assign out_operation = ctl_q.operation;
    assign out_rd        = rd_q;
    assign out_reg_write = reg_write_q;
    assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Bench for id_ex_alu_issue: directed vectors with hand-computed results,
// expected beats queued at transfer and popped by an independent monitor.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_rs1, in_rs2, in_imm;
    logic        in_alu_src;
    logic [1:0]  in_alu_op;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b;
    logic        out_ainvert, out_binvert, out_carry_in;
    logic [1:0]  out_operation;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ainv;
        logic        binv;
        logic        cin;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } beat_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        src;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] eb;
        logic [3:0]  ectl;
        logic        eill;
        logic        erw;
    } vec_t;

    beat_t sb_q[$];
    vec_t  vecs[14];

    id_ex_alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_alu_src(in_alu_src), .in_alu_op(in_alu_op),
        .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b),
        .out_ainvert(out_ainvert), .out_binvert(out_binvert),
        .out_carry_in(out_carry_in), .out_operation(out_operation),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic src, input logic [4:0] rd,
                                input logic rw, input logic [31:0] eb, input logic [3:0] ectl,
                                input logic eill, input logic erw);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.src = src; v.rd = rd; v.rw = rw; v.eb = eb; v.ectl = ectl;
        v.eill = eill; v.erw = erw;
        return v;
    endfunction

    function automatic beat_t to_exp(input vec_t v);
        beat_t e;
        e.a    = v.rs1;
        e.b    = v.eb;
        e.ainv = v.ectl[3];
        e.binv = v.ectl[2];
        e.cin  = v.ectl[2];
        e.op   = v.ectl[1:0];
        e.rd   = v.rd;
        e.rw   = v.erw;
        e.ill  = v.eill;
        return e;
    endfunction

    function automatic beat_t cur();
        beat_t c;
        c.a = out_a; c.b = out_b; c.ainv = out_ainvert; c.binv = out_binvert;
        c.cin = out_carry_in; c.op = out_operation; c.rd = out_rd;
        c.rw = out_reg_write; c.ill = out_illegal;
        return c;
    endfunction

    task automatic drive(input vec_t v);
        in_alu_op    = v.op;
        in_funct3    = v.f3;
        in_funct7_5  = v.f7;
        in_rs1       = v.rs1;
        in_rs2       = v.rs2;
        in_imm       = v.imm;
        in_alu_src   = v.src;
        in_rd        = v.rd;
        in_reg_write = v.rw;
    endtask

    // Present one beat, wait (bounded) for in_ready, queue its expectation at the transfer edge.
    task automatic send(input vec_t v);
        bit ok = 1'b0;
        drive(v);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("send_timeout", {127'd0, in_ready}, 128'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (!flush) sb_q.push_back(to_exp(v));
        #1 in_valid = 1'b0;
    endtask

    // Monitor: every completed downstream beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", {52'd0, cur()}, 128'd0);
            end else begin
                check("beat", {52'd0, cur()}, {52'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        //                op     f3     f7   rs1           rs2           imm           src   rd     rw    exp_b         ctl      ill   rw_o
        vecs[0]  = mk(2'b10, 3'b000, 1'b1, 32'd5,        32'd3,        32'h0,        1'b0, 5'd1,  1'b1, 32'd3,        4'b0110, 1'b0, 1'b1); // SUB
        vecs[1]  = mk(2'b11, 3'b000, 1'b0, 32'd7,        32'h1234,     32'hFFFFFFFF, 1'b1, 5'd2,  1'b1, 32'hFFFFFFFF, 4'b0010, 1'b0, 1'b1); // ADDI
        vecs[2]  = mk(2'b10, 3'b111, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h55,       1'b0, 5'd3,  1'b1, 32'h0FF00FF0, 4'b0000, 1'b0, 1'b1); // AND
        vecs[3]  = mk(2'b10, 3'b110, 1'b0, 32'h00000011, 32'h00000100, 32'h66,       1'b0, 5'd4,  1'b1, 32'h00000100, 4'b0001, 1'b0, 1'b1); // OR
        vecs[4]  = mk(2'b10, 3'b010, 1'b0, 32'h80000000, 32'h00000001, 32'h77,       1'b0, 5'd5,  1'b1, 32'h00000001, 4'b0111, 1'b0, 1'b1); // SLT
        vecs[5]  = mk(2'b10, 3'b000, 1'b0, 32'hDEADBEEF, 32'h01234567, 32'h88,       1'b0, 5'd6,  1'b1, 32'h01234567, 4'b0010, 1'b0, 1'b1); // ADD
        vecs[6]  = mk(2'b00, 3'b010, 1'b0, 32'h00001000, 32'hAAAA5555, 32'h00000010, 1'b1, 5'd7,  1'b1, 32'h00000010, 4'b0010, 1'b0, 1'b1); // LW addr
        vecs[7]  = mk(2'b01, 3'b000, 1'b0, 32'h00000009, 32'h00000009, 32'h00000040, 1'b0, 5'd0,  1'b0, 32'h00000009, 4'b0110, 1'b0, 1'b0); // BEQ
        vecs[8]  = mk(2'b11, 3'b110, 1'b1, 32'h12340000, 32'h0,        32'h000000FF, 1'b1, 5'd8,  1'b1, 32'h000000FF, 4'b0001, 1'b0, 1'b1); // ORI, f7 ignored
        vecs[9]  = mk(2'b11, 3'b010, 1'b0, 32'hFFFFFFFE, 32'h0,        32'hFFFFFFFF, 1'b1, 5'd9,  1'b1, 32'hFFFFFFFF, 4'b0111, 1'b0, 1'b1); // SLTI
        vecs[10] = mk(2'b11, 3'b111, 1'b0, 32'h0000FFFF, 32'h0,        32'h00000F0F, 1'b1, 5'd10, 1'b1, 32'h00000F0F, 4'b0000, 1'b0, 1'b1); // ANDI
        vecs[11] = mk(2'b10, 3'b001, 1'b0, 32'h00000001, 32'h00000002, 32'h0,        1'b0, 5'd11, 1'b1, 32'h00000002, 4'b0010, 1'b1, 1'b0); // R f3=001
        vecs[12] = mk(2'b10, 3'b010, 1'b1, 32'h00000003, 32'h00000004, 32'h0,        1'b0, 5'd12, 1'b1, 32'h00000004, 4'b0010, 1'b1, 1'b0); // SLT f7=1
        vecs[13] = mk(2'b11, 3'b001, 1'b0, 32'h00000005, 32'h0,        32'h00000003, 1'b1, 5'd13, 1'b1, 32'h00000003, 4'b0010, 1'b1, 1'b0); // I f3=001

        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(vecs[0]);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_valid", {127'd0, out_valid}, 128'd0);
        check("reset_outs", {52'd0, cur()}, 128'd0);
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back stream through every decode case.
        for (int i = 0; i < 14; i++) send(vecs[i]);
        repeat (3) @(posedge clk);
        #1 check("stream_drained", {96'd0, 32'(sb_q.size())}, 128'd0);
        check("idle_valid", {127'd0, out_valid}, 128'd0);

        // Stall: held beat stays bit-stable, next beat waits, then loads on release.
        out_ready = 1'b0;
        send(vecs[0]);
        drive(vecs[1]);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {127'd0, in_ready}, 128'd0);
            check("stall_hold", {52'd0, cur()}, {52'd0, to_exp(vecs[0])});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        sb_q.push_back(to_exp(vecs[1]));
        #1 in_valid = 1'b0;
        check("release_load", {52'd0, cur()}, {52'd0, to_exp(vecs[1])});
        check("release_valid", {127'd0, out_valid}, 128'd1);
        repeat (2) @(posedge clk);
        #1;

        // Flush: held beat killed, incoming beat dropped, payload registers unchanged.
        out_ready = 1'b0;
        send(vecs[2]);
        drive(vecs[3]);
        in_valid = 1'b1;
        out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        sb_q.delete();
        #1 flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {127'd0, out_valid}, 128'd0);
        repeat (3) @(posedge clk);
        #1 check("flush_no_beat", {127'd0, out_valid}, 128'd0);
        check("flush_data_kept", {96'd0, out_a}, {96'd0, vecs[2].rs1});
        send(vecs[4]);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset while a beat is held.
        out_ready = 1'b0;
        send(vecs[5]);
        check("pre_reset_valid", {127'd0, out_valid}, 128'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", {127'd0, out_valid}, 128'd0);
        check("async_reset_outs", {52'd0, cur()}, 128'd0);
        check("async_reset_in_ready", {127'd0, in_ready}, 128'd1);
        sb_q.delete();
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(vecs[11]);
        repeat (3) @(posedge clk);
        #1 check("final_drained", {96'd0, 32'(sb_q.size())}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
